// File: rtl/ready_out_handshake_pkg.sv
// Shared types and default sizing for the picoNISC output-side handshake generator.
package ready_out_pkg;

  localparam int RO_DATA_W    = 16;
  localparam int RO_HOLD_BITS = 4;

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_ACK, GAP} ro_state_t;

endpackage

// File: rtl/ready_out_handshake_if.sv
// Bundles the CPU strobe/data, the external acknowledge and the handshake outputs.
interface ready_out_handshake_if
  import ready_out_pkg::*;
#(
  parameter int DATA_W = RO_DATA_W
);

  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              ack_in;
  logic [DATA_W-1:0] data_out;
  logic              ready_out;
  logic              busy;

  modport master (
    output wr,
    output wdata,
    output ack_in,
    input  data_out,
    input  ready_out,
    input  busy
  );

  modport slave (
    input  wr,
    input  wdata,
    input  ack_in,
    output data_out,
    output ready_out,
    output busy
  );

endinterface

// File: rtl/ready_out_handshake_ack_sync.sv
// Brings the asynchronous acknowledge into the clk domain and flags its rising edge.
module ack_sync (
  input  logic clk,
  input  logic Reset,
  input  logic in,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // s3 only delays s2, so a level held high produces a single rise
  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ready_out_handshake.sv
// Output handshake: latches a CPU word, holds ready_out for a minimum time until acked, then a fixed gap.
module ready_out_handshake
  import ready_out_pkg::*;
#(
  parameter int DATA_W    = RO_DATA_W,
  parameter int HOLD_BITS = RO_HOLD_BITS
) (
  input logic                  clk,
  input logic                  Reset,
  ready_out_handshake_if.slave io_bus
);

  ro_state_t             r_state;
  ro_state_t             w_state_next;
  logic [HOLD_BITS-1:0]  r_count;
  logic [HOLD_BITS-1:0]  w_count_next;
  logic                  r_ack_seen;
  logic                  w_ack_seen_next;
  logic [DATA_W-1:0]     r_data;
  logic                  w_load;
  logic                  w_ack_rise;
  logic                  w_count_full;

  ack_sync u_ack_sync (
    .clk   (clk),
    .Reset (Reset),
    .in    (io_bus.ack_in),
    .rise  (w_ack_rise)
  );

  assign w_count_full = &r_count;

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_ack_seen_next = r_ack_seen;
    w_load          = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.wr) begin
          w_load          = 1'b1;
          w_count_next    = '0;
          w_ack_seen_next = 1'b0;
          w_state_next    = HOLD;
        end
      end
      HOLD: begin
        w_count_next = r_count + 1'b1;
        if (w_ack_rise) begin
          w_ack_seen_next = 1'b1;
        end
        // An ack arriving on the very last hold cycle still counts
        if (w_count_full) begin
          w_count_next = '0;
          w_state_next = (r_ack_seen || w_ack_rise) ? GAP : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_ack_rise) begin
          w_count_next = '0;
          w_state_next = GAP;
        end
      end
      GAP: begin
        w_count_next = r_count + 1'b1;
        if (w_count_full) begin
          w_count_next = '0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_ack_seen <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_ack_seen <= w_ack_seen_next;
      if (w_load) begin
        r_data <= io_bus.wdata;
      end
    end
  end

  // Outputs decode the state register only, so wr/ack_in never reach them combinationally
  assign io_bus.ready_out = (r_state == HOLD) || (r_state == WAIT_ACK);
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.data_out  = r_data;

endmodule
